test_reporter: RTL and testbench
================================

TEST_REPORTER -- requirements
Module: test_reporter

Interface
REQ-001 Parameter DEF_DIV, default 434, reset value of the baud divisor (clk cycles per UART bit).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 we_i  input  1  bus write strobe, one-cycle qualified.
REQ-005 addr_i  input  32  byte address; only addr_i[3:2] decoded.
REQ-006 data_i  input  32  bus write data.
REQ-007 data_o  output  32  combinational read data for addr_i.
REQ-008 tx_o  output  1  UART serial out, 8N1, LSB first, idle high.
REQ-009 done_o  output  1  test-program-finished flag.
REQ-010 pass_o  output  1  test-result flag, valid when done_o=1.

Function
REQ-011 The register map SHALL be: 0x0 CTRL (W: bit0 done, bit1 pass); 0x4 TESTNUM (RW, 32 bit); 0x8 STATUS (RO: bit0 busy, bit1 done, bit2 pass, bit3 overrun); 0xC DIV (RW, bits[15:0]).
REQ-012 Reads of unmapped bits SHALL return 0; writes to STATUS SHALL have no effect.
REQ-013 A CTRL write with data_i[0]=1 while not busy SHALL, on the next clock edge, set done_o=1, set pass_o=data_i[1], snapshot TESTNUM and DIV, and enter state START.
REQ-014 A CTRL write with data_i[0]=0 while not busy SHALL clear done_o and pass_o and send nothing.
REQ-015 A CTRL write while busy SHALL be ignored, except that STATUS.overrun SHALL be set (sticky until reset).
REQ-016 A TESTNUM or DIV write while busy SHALL update the register but SHALL NOT alter the frame in flight.
REQ-017 A frame SHALL be 6 bytes in order: 0xA5, {6'b0, pass, done}, TESTNUM[7:0], [15:8], [23:16], [31:24].
REQ-018 Each byte SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit SHALL be held exactly div clk cycles.
REQ-019 Effective div SHALL be max(DIV, 2); DIV values 0 and 1 SHALL be treated as 2.
REQ-020 Frame FSM states SHALL be IDLE -> START -> DATA(8 bits) -> STOP -> (next byte: START | last byte: IDLE); bytes SHALL be sent back-to-back with no idle gap.
REQ-021 The start bit of byte 0 SHALL appear on tx_o on the edge that registers the triggering CTRL write, making tx_o low in the cycle after the write.
REQ-022 busy SHALL be 1 from that edge until the final stop bit has completed its div cycles; a new trigger SHALL be accepted in the first cycle busy=0.
REQ-023 tx_o SHALL be driven from a flop (glitch-free).

Reset
REQ-024 On rst: tx_o=1, done_o=0, pass_o=0, TESTNUM=0, DIV=DEF_DIV, overrun=0, FSM=IDLE, all counters 0.
REQ-025 A reset asserted mid-frame SHALL abort the frame immediately with tx_o=1; no partial byte SHALL resume after release.

Structure
REQ-026 Shared package SHALL hold register offsets (CTRL/TESTNUM/STATUS/DIV), the 0xA5 sync byte, frame length 6, and the FSM state enum.
REQ-027 One sub-module uart_tx_byte (byte in, valid/ready handshake, div input, tx out) SHALL perform bit serialisation; test_reporter SHALL sequence bytes into it.

Verification
REQ-028 Reset with DEF_DIV=4: tx_o=1, done_o=0, pass_o=0, STATUS read=0x0, DIV read=0x4.
REQ-029 DIV=4, TESTNUM=0x12345678, CTRL=0x3 -> done_o=1, pass_o=1 next cycle; tx_o decodes A5 03 78 56 34 12; busy for exactly 240 cycles.
REQ-030 TESTNUM=0x0000000B, CTRL=0x1 -> frame A5 01 0B 00 00 00; pass_o=0; STATUS=0x3 during the frame, 0x2 after it.
REQ-031 CTRL=0x3 then CTRL=0x1 and TESTNUM=0x99 mid-frame -> frame unchanged (testnum bytes 78 56 34 12), pass_o stays 1, STATUS.overrun=1.
REQ-032 DIV=0 then trigger -> every bit lasts 2 cycles; 6-byte frame lasts 120 cycles.
REQ-033 rst pulse during byte 2 -> tx_o=1 within the reset, all flags 0; after release tx_o stays high with no further transitions until a new trigger.

Source files
------------

// File: rtl/test_reporter_pkg.sv
// Shared definitions for the test reporter: register offsets, frame constants
// and the serialiser state encoding.
package test_reporter_pkg;

    localparam logic [31:0] CTRL_OFF    = 32'h0000_0000;
    localparam logic [31:0] TESTNUM_OFF = 32'h0000_0004;
    localparam logic [31:0] STATUS_OFF  = 32'h0000_0008;
    localparam logic [31:0] DIV_OFF     = 32'h0000_000C;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [2:0] FRAME_LEN = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // A bit time below two cycles is not meaningful, so small divisors are clamped.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        logic [15:0] res;
        if (div < 16'd2) begin
            res = 16'd2;
        end else begin
            res = div;
        end
        return res;
    endfunction

endpackage

// File: rtl/test_reporter_uart_tx_byte.sv
// 8N1 byte serialiser. A new byte offered during the last stop-bit cycle is
// accepted directly, so consecutive bytes leave without an idle gap.
module uart_tx_byte
    import test_reporter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [15:0] div_i,
    output logic        tx_o
);

    tx_state_e   state_r;
    logic [15:0] cnt_r;
    logic [15:0] div_r;
    logic [2:0]  bit_r;
    logic [7:0]  sh_r;
    logic        tx_r;
    logic        bit_end_s;

    // Bit-period end detection and handshake readiness.
    always_comb begin
        bit_end_s = (cnt_r == (div_r - 16'd1));
        if (state_r == ST_IDLE) begin
            ready_o = 1'b1;
        end else if (state_r == ST_STOP) begin
            ready_o = bit_end_s;
        end else begin
            ready_o = 1'b0;
        end
    end

    // Bit sequencing FSM; tx_r is the only driver of the serial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            tx_r    <= 1'b1;
            cnt_r   <= 16'd0;
            div_r   <= 16'd0;
            bit_r   <= 3'd0;
            sh_r    <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (valid_i) begin
                        sh_r    <= byte_i;
                        div_r   <= div_i;
                        cnt_r   <= 16'd0;
                        bit_r   <= 3'd0;
                        tx_r    <= 1'b0;
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        cnt_r   <= 16'd0;
                        bit_r   <= 3'd0;
                        tx_r    <= sh_r[0];
                        state_r <= ST_DATA;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        cnt_r <= 16'd0;
                        if (bit_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= ST_STOP;
                        end else begin
                            bit_r <= bit_r + 3'd1;
                            sh_r  <= {1'b0, sh_r[7:1]};
                            tx_r  <= sh_r[1];
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        cnt_r <= 16'd0;
                        if (valid_i) begin
                            sh_r    <= byte_i;
                            div_r   <= div_i;
                            bit_r   <= 3'd0;
                            tx_r    <= 1'b0;
                            state_r <= ST_START;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    cnt_r   <= 16'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_o = tx_r;

endmodule

// File: rtl/test_reporter.sv
// Memory-mapped test-result reporter: latches done/pass on a CTRL write and
// streams a 6-byte result frame out of a UART.
module test_reporter
    import test_reporter_pkg::*;
#(
    parameter logic [15:0] DEF_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        done_o,
    output logic        pass_o
);

    logic [31:0] testnum_r;
    logic [15:0] div_r;
    logic        done_r;
    logic        pass_r;
    logic        overrun_r;
    logic        busy_r;
    logic [2:0]  byte_idx_r;
    logic [31:0] tn_snap_r;
    logic [15:0] div_snap_r;

    logic        ctrl_wr_s;
    logic        tn_wr_s;
    logic        div_wr_s;
    logic        trigger_s;
    logic [7:0]  frame_byte_s;
    logic [7:0]  byte_s;
    logic [15:0] byte_div_s;
    logic        byte_valid_s;
    logic        uart_ready_s;
    logic        unused_addr_s;

    assign unused_addr_s = ^{addr_i[31:4], addr_i[1:0]};

    // Write decode and trigger qualification.
    always_comb begin
        ctrl_wr_s = we_i && (addr_i[3:2] == CTRL_OFF[3:2]);
        tn_wr_s   = we_i && (addr_i[3:2] == TESTNUM_OFF[3:2]);
        div_wr_s  = we_i && (addr_i[3:2] == DIV_OFF[3:2]);
        trigger_s = ctrl_wr_s && data_i[0] && !busy_r;
    end

    // Byte selection; byte 0 is fed straight from the trigger so the start bit
    // lands on the same edge that registers the write.
    always_comb begin
        case (byte_idx_r)
            3'd0:    frame_byte_s = SYNC_BYTE;
            3'd1:    frame_byte_s = {6'b000000, pass_r, done_r};
            3'd2:    frame_byte_s = tn_snap_r[7:0];
            3'd3:    frame_byte_s = tn_snap_r[15:8];
            3'd4:    frame_byte_s = tn_snap_r[23:16];
            3'd5:    frame_byte_s = tn_snap_r[31:24];
            default: frame_byte_s = 8'h00;
        endcase
        if (trigger_s) begin
            byte_s       = SYNC_BYTE;
            byte_div_s   = eff_div(div_r);
            byte_valid_s = 1'b1;
        end else begin
            byte_s       = frame_byte_s;
            byte_div_s   = div_snap_r;
            byte_valid_s = busy_r && (byte_idx_r < FRAME_LEN);
        end
    end

    // Software-visible registers and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            testnum_r <= 32'd0;
            div_r     <= DEF_DIV;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (tn_wr_s) begin
                testnum_r <= data_i;
            end
            if (div_wr_s) begin
                div_r <= data_i[15:0];
            end
            if (ctrl_wr_s) begin
                if (busy_r) begin
                    overrun_r <= 1'b1;
                end else begin
                    done_r <= data_i[0];
                    pass_r <= data_i[0] & data_i[1];
                end
            end
        end
    end

    // Frame sequencer: busy ends when the serialiser finishes the final stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= 1'b0;
            byte_idx_r <= 3'd0;
            tn_snap_r  <= 32'd0;
            div_snap_r <= 16'd0;
        end else if (trigger_s) begin
            busy_r     <= 1'b1;
            byte_idx_r <= 3'd1;
            tn_snap_r  <= testnum_r;
            div_snap_r <= eff_div(div_r);
        end else if (busy_r && uart_ready_s) begin
            if (byte_idx_r == FRAME_LEN) begin
                busy_r     <= 1'b0;
                byte_idx_r <= 3'd0;
            end else begin
                byte_idx_r <= byte_idx_r + 3'd1;
            end
        end
    end

    // Combinational register read-back.
    always_comb begin
        case (addr_i[3:2])
            TESTNUM_OFF[3:2]: data_o = testnum_r;
            STATUS_OFF[3:2]:  data_o = {28'd0, overrun_r, pass_r, done_r, busy_r};
            DIV_OFF[3:2]:     data_o = {16'd0, div_r};
            default:          data_o = 32'd0;
        endcase
    end

    uart_tx_byte u_tx (
        .clk     (clk),
        .rst     (rst),
        .byte_i  (byte_s),
        .valid_i (byte_valid_s),
        .ready_o (uart_ready_s),
        .div_i   (byte_div_s),
        .tx_o    (tx_o)
    );

    assign done_o = done_r;
    assign pass_o = pass_r;

endmodule

// File: tb/tb_test_reporter.sv
// Self-checking bench: a per-cycle waveform model of the frame plus an
// independent UART decoder and literal expectations for each scenario.
module tb_test_reporter;

    localparam int DIV0 = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;
    logic        done;
    logic        pass;

    test_reporter #(.DEF_DIV(16'(DIV0))) dut (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we),
        .addr_i (addr),
        .data_i (wdata),
        .data_o (rdata),
        .tx_o   (tx),
        .done_o (done),
        .pass_o (pass)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    bit          exp_q[$];
    logic [31:0] m_tn;
    logic [15:0] m_div;
    logic        m_done, m_pass, m_ovr, m_busy_now;
    int          busy_cnt, dut_busy_cnt, trans_cnt;
    logic        last_tx = 1'b1;

    // decoder state
    logic [7:0]  rx_q[$];
    int          rx_div = DIV0;
    int          rx_pos;
    bit          rx_act = 1'b0;
    logic [7:0]  rx_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_tn = 32'd0;
        m_div = 16'(DIV0);
        m_done = 1'b0;
        m_pass = 1'b0;
        m_ovr = 1'b0;
        m_busy_now = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[3:2])
            2'd1:    return m_tn;
            2'd2:    return {28'd0, m_ovr, m_pass, m_done, m_busy_now};
            2'd3:    return {16'd0, m_div};
            default: return 32'd0;
        endcase
    endfunction

    // Expand the frame into the expected tx level for every cycle.
    task automatic push_frame();
        logic [7:0] fb[6];
        int d;
        d = (m_div < 16'd2) ? 2 : int'(m_div);
        fb[0] = 8'hA5;
        fb[1] = {6'd0, m_pass, m_done};
        fb[2] = m_tn[7:0];
        fb[3] = m_tn[15:8];
        fb[4] = m_tn[23:16];
        fb[5] = m_tn[31:24];
        for (int b = 0; b < 6; b++) begin
            repeat (d) exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (d) exp_q.push_back(fb[b][i]);
            repeat (d) exp_q.push_back(1'b1);
        end
        rx_div = d;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        case (a[3:2])
            2'd0: begin
                if (m_busy_now) begin
                    m_ovr = 1'b1;
                end else if (d[0]) begin
                    m_done = 1'b1;
                    m_pass = d[1];
                    busy_cnt = 0;
                    dut_busy_cnt = 0;
                    rx_q.delete();
                    push_frame();
                end else begin
                    m_done = 1'b0;
                    m_pass = 1'b0;
                end
            end
            2'd1:    m_tn = d;
            2'd3:    m_div = d[15:0];
            default: ;
        endcase
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        bit e;
        m_busy_now = (exp_q.size() > 0);
        e = m_busy_now ? exp_q.pop_front() : 1'b1;
        check("tx_o", 32'(tx), 32'(e));
        check("done_o", 32'(done), 32'(m_done));
        check("pass_o", 32'(pass), 32'(m_pass));
        check("data_o", rdata, m_read(addr));
        if (m_busy_now) busy_cnt++;
        if (addr == 32'h8 && rdata[0]) dut_busy_cnt++;
        if (tx !== last_tx) trans_cnt++;
        last_tx = tx;
    end

    // Independent UART receiver sampling mid-bit.
    always @(negedge clk) begin
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx == 1'b0) begin
                rx_act = 1'b1;
                rx_pos = 0;
            end
        end else begin
            rx_pos++;
            for (int k = 0; k < 8; k++)
                if (rx_pos == rx_div * (k + 1) + rx_div / 2) rx_byte[k] = tx;
            if (rx_pos == rx_div * 9 + rx_div / 2) begin
                rx_q.push_back(rx_byte);
                rx_act = 1'b0;
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wdata = d;
        we = 1'b1;
        @(posedge clk);
        model_write(a, d);
        #1;
        we = 1'b0;
        addr = 32'h8;
        wdata = 32'd0;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (m_busy_now && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (m_busy_now) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: still busy after %0d cycles, required idle", limit);
        end
    endtask

    task automatic check_frame(input string tag, input logic [47:0] exp);
        logic [7:0] b;
        check({tag, "_rx_count"}, 32'(rx_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < rx_q.size()) begin
                b = exp[47 - 8 * i -: 8];
                check($sformatf("%s_rx_byte%0d", tag, i), 32'(rx_q[i]), 32'(b));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        we = 1'b0;
        addr = 32'h8;
        wdata = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;

        // reset state
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_status", rdata, 32'h0);
        addr = 32'hC;
        #1 check("rst_div", rdata, 32'h4);
        addr = 32'h8;
        @(negedge clk);
        #1;

        // full pass frame
        wr(32'h4, 32'h1234_5678);
        wr(32'h0, 32'h3);
        check("A_done", 32'(done), 32'd1);
        check("A_pass", 32'(pass), 32'd1);
        wait_idle(1000);
        check_frame("A", 48'hA5_03_78_56_34_12);
        check("A_busy_model", 32'(busy_cnt), 32'd240);
        check("A_busy_dut", 32'(dut_busy_cnt), 32'd240);

        // fail frame, STATUS during/after
        wr(32'h4, 32'h0000_000B);
        wr(32'h0, 32'h1);
        check("B_pass", 32'(pass), 32'd0);
        repeat (20) @(negedge clk);
        #1 check("B_status_busy", rdata, 32'h3);
        wait_idle(1000);
        check("B_status_after", rdata, 32'h2);
        check_frame("B", 48'hA5_01_0B_00_00_00);

        // writes during a frame
        wr(32'h4, 32'h1234_5678);
        wr(32'h0, 32'h3);
        repeat (30) @(negedge clk);
        #1;
        wr(32'h0, 32'h1);
        wr(32'h4, 32'h0000_0099);
        check("C_pass", 32'(pass), 32'd1);
        check("C_status_busy", rdata, 32'hF);
        wait_idle(1000);
        check_frame("C", 48'hA5_03_78_56_34_12);
        check("C_status_after", rdata, 32'hE);
        addr = 32'h4;
        #1 check("C_testnum", rdata, 32'h99);
        addr = 32'h8;
        @(negedge clk);
        #1;

        // DIV=0 clamps to 2, then back-to-back retrigger
        wr(32'hC, 32'h0);
        wr(32'h0, 32'h3);
        wait_idle(1000);
        check("D_busy_model", 32'(busy_cnt), 32'd120);
        check("D_busy_dut", 32'(dut_busy_cnt), 32'd120);
        check_frame("D", 48'hA5_03_99_00_00_00);
        wr(32'h0, 32'h1);
        check("D2_done", 32'(done), 32'd1);
        wait_idle(1000);
        check("D2_busy_dut", 32'(dut_busy_cnt), 32'd120);
        check_frame("D2", 48'hA5_01_99_00_00_00);

        // reset during byte 2
        wr(32'hC, 32'h4);
        wr(32'h0, 32'h3);
        repeat (85) @(negedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("E_rst_tx", 32'(tx), 32'd1);
        check("E_rst_done", 32'(done), 32'd0);
        check("E_rst_pass", 32'(pass), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        trans_cnt = 0;
        repeat (50) @(negedge clk);
        #1;
        check("E_no_toggle", 32'(trans_cnt), 32'd0);
        check("E_tx_idle", 32'(tx), 32'd1);
        check("E_status", rdata, 32'h0);
        addr = 32'hC;
        #1 check("E_div", rdata, 32'h4);
        addr = 32'h8;
        @(negedge clk);
        #1;

        // fresh frame after reset
        wr(32'h0, 32'h3);
        wait_idle(1000);
        check_frame("F", 48'hA5_03_00_00_00_00);
        check("F_busy_dut", 32'(dut_busy_cnt), 32'd240);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
